// File: rtl/spi_pixel_writer_if.sv
// Pixel write port from the SPI receiver into frame RAM.
// The master drives a one-cycle strobe with its address and data.
interface spi_pixel_writer_if #(
  parameter int BITS_PER_PIXEL = 16
);
  logic                      wr_en;
  logic [10:0]               wr_addr;
  logic [BITS_PER_PIXEL-1:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/spi_pixel_writer.sv
// SPI mode-0 slave that assembles pixels and writes them into a
// double-buffered frame RAM, flipping buffers on each complete frame.
module spi_pixel_writer #(
  parameter int BITS_PER_PIXEL   = 16,
  parameter int PIXELS_PER_FRAME = 1024
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_ss,
  spi_pixel_writer_if.master wr,
  output logic               display_buf,
  output logic               frame_done,
  output logic               overflow
);

  localparam int W   = BITS_PER_PIXEL;
  localparam int BCW = $clog2(W + 1);

  localparam logic [BCW-1:0] BITS_L = BCW'(W);
  localparam logic [10:0]    PPF_L  = 11'(PIXELS_PER_FRAME);

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    COMMIT
  } state_t;

  state_t         state;
  logic [2:0]     sclk_q;
  logic [2:0]     ss_q;
  logic [1:0]     mosi_q;
  logic [BCW-1:0] bit_cnt;
  logic [10:0]    pix_idx;
  logic [W-1:0]   shreg;

  logic clk_rise;
  logic ss_fall;
  logic ss_rise;

  assign clk_rise = sclk_q[1] & ~sclk_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];

  // Resynchronise host signals; bit 2 is the edge-detect history.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sclk_q <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      ss_q   <= {ss_q[1:0], spi_ss};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  // Frame FSM: shift bits, emit pixel writes, commit on ss release.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      wr.wr_en    <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
      display_buf <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      bit_cnt     <= '0;
      pix_idx     <= '0;
      shreg       <= '0;
    end else begin
      wr.wr_en   <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            state    <= RECEIVE;
            bit_cnt  <= '0;
            pix_idx  <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
          end
        end
        RECEIVE: begin
          if (bit_cnt == BITS_L) begin
            bit_cnt <= '0;
            if (pix_idx == PPF_L) begin
              overflow <= 1'b1;
            end else begin
              wr.wr_en   <= 1'b1;
              wr.wr_addr <= {~display_buf, pix_idx[9:0]};
              wr.wr_data <= shreg;
              pix_idx    <= pix_idx + 11'd1;
            end
          end else if (clk_rise) begin
            shreg   <= {shreg[W-2:0], mosi_q[1]};
            bit_cnt <= bit_cnt + BCW'(1);
          end
          // A partial word left in shreg is simply dropped.
          if (ss_rise) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          if (pix_idx == PPF_L) begin
            display_buf <= ~display_buf;
            frame_done  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pixel_writer.sv
// Directed bench for spi_pixel_writer with a 128-pixel frame
// so full-frame scenarios stay short.
module tb_spi_pixel_writer;

  localparam int BPP = 16;
  localparam int PPF = 128;

  logic clk;
  logic n_reset;
  logic spi_clk;
  logic spi_mosi;
  logic spi_ss;
  logic display_buf;
  logic frame_done;
  logic overflow;

  int checks;
  int failures;

  logic [10:0]    wa[$];
  logic [BPP-1:0] wd[$];
  int   fd_cnt;
  int   dbl;
  logic prev_en;

  spi_pixel_writer_if #(.BITS_PER_PIXEL(BPP)) wr_bus ();

  spi_pixel_writer #(
    .BITS_PER_PIXEL  (BPP),
    .PIXELS_PER_FRAME(PPF)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_ss     (spi_ss),
    .wr         (wr_bus),
    .display_buf(display_buf),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor on the falling edge.
  initial begin
    fd_cnt  = 0;
    dbl     = 0;
    prev_en = 1'b0;
  end

  always @(negedge clk) begin
    if (wr_bus.wr_en === 1'b1) begin
      wa.push_back(wr_bus.wr_addr);
      wd.push_back(wr_bus.wr_data);
      if (prev_en === 1'b1) dbl++;
    end
    prev_en = wr_bus.wr_en;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = w[15-i];
      #20 spi_clk = 1'b1;
      #20 spi_clk = 1'b0;
    end
  endtask

  task automatic ss_low();
    spi_ss = 1'b0;
    #100;
  endtask

  task automatic ss_high();
    #40 spi_ss = 1'b1;
    #100;
  endtask

  task automatic test_reset();
    n_reset  = 1'b0;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_ss   = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_bus.wr_en !== 1'b0 || wr_bus.wr_addr !== 11'h0 ||
        wr_bus.wr_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_bus en=%b addr=%h data=%h want 0/0/0",
               wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data);
    end
    checks++;
    if (display_buf !== 1'b0 || frame_done !== 1'b0 ||
        overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags db=%b fd=%b ov=%b want 0/0/0",
               display_buf, frame_done, overflow);
    end
    n_reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_pixel();
    int b;
    int f;
    b = wa.size();
    f = fd_cnt;
    ss_low();
    send_bits(16'hA5C3, 16);
    ss_high();
    checks++;
    if (wa.size() - b !== 1) begin
      failures++;
      $display("FAIL single_count got=%0d want=1", wa.size() - b);
    end else begin
      checks++;
      if (wd[b] !== 16'hA5C3 || wa[b] !== 11'h400) begin
        failures++;
        $display("FAIL single_word data=%h addr=%h want a5c3/400",
                 wd[b], wa[b]);
      end
    end
    checks++;
    if (fd_cnt !== f || display_buf !== 1'b0) begin
      failures++;
      $display("FAIL single_nofd fd=%0d db=%b want 0/0",
               fd_cnt - f, display_buf);
    end
  endtask

  task automatic test_partial_word();
    int b;
    int f;
    b = wa.size();
    f = fd_cnt;
    ss_low();
    send_bits(16'h1234, 16);
    send_bits(16'hFE00, 7);
    ss_high();
    checks++;
    if (wa.size() - b !== 1) begin
      failures++;
      $display("FAIL partial_count got=%0d want=1", wa.size() - b);
    end
    checks++;
    if (fd_cnt !== f) begin
      failures++;
      $display("FAIL partial_fd got=%0d want=0", fd_cnt - f);
    end
    checks++;
    if (wr_bus.wr_data !== 16'h1234 || wr_bus.wr_addr !== 11'h400) begin
      failures++;
      $display("FAIL partial_hold data=%h addr=%h want 1234/400",
               wr_bus.wr_data, wr_bus.wr_addr);
    end
  endtask

  task automatic test_reset_mid_frame();
    int b;
    int f;
    b = wa.size();
    f = fd_cnt;
    ss_low();
    for (int i = 0; i < 100; i++) send_bits(16'(i), 16);
    send_bits(16'hFFFF, 5);
    #40;
    checks++;
    if (wa.size() - b !== 100) begin
      failures++;
      $display("FAIL midrst_pre got=%0d want=100", wa.size() - b);
    end
    @(negedge clk);
    n_reset = 1'b0;
    spi_ss  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_bus.wr_en !== 1'b0 || wr_bus.wr_addr !== 11'h0 ||
        wr_bus.wr_data !== 16'h0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out en=%b addr=%h data=%h ov=%b want 0",
               wr_bus.wr_en, wr_bus.wr_addr, wr_bus.wr_data, overflow);
    end
    n_reset = 1'b1;
    b = wa.size();
    send_bits(16'hBEEF, 16);
    send_bits(16'hCAFE, 16);
    #200;
    checks++;
    if (wa.size() !== b || fd_cnt !== f || display_buf !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet wr=%0d fd=%0d db=%b want 0/0/0",
               wa.size() - b, fd_cnt - f, display_buf);
    end
  endtask

  task automatic test_full_frame();
    int   b;
    int   f;
    int   bad;
    logic [10:0] ea;
    b   = wa.size();
    f   = fd_cnt;
    bad = 0;
    ss_low();
    for (int i = 0; i < PPF; i++) send_bits(16'(i), 16);
    ss_high();
    checks++;
    if (wa.size() - b !== PPF) begin
      failures++;
      $display("FAIL frame1_count got=%0d want=%0d", wa.size() - b, PPF);
    end else begin
      for (int i = 0; i < PPF; i++) begin
        ea = 11'h400 | 11'(i);
        if (wa[b+i] !== ea || wd[b+i] !== 16'(i)) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL frame1_words bad=%0d want=0", bad);
      end
      checks++;
      if (wa[b+PPF-1] !== 11'h47F) begin
        failures++;
        $display("FAIL frame1_last got=%h want=47f", wa[b+PPF-1]);
      end
    end
    checks++;
    if (fd_cnt - f !== 1 || display_buf !== 1'b1) begin
      failures++;
      $display("FAIL frame1_commit fd=%0d db=%b want 1/1",
               fd_cnt - f, display_buf);
    end
    b   = wa.size();
    bad = 0;
    ss_low();
    for (int i = 0; i < PPF; i++) send_bits(16'hFF00 | 16'(i), 16);
    ss_high();
    checks++;
    if (wa.size() - b !== PPF) begin
      failures++;
      $display("FAIL frame2_count got=%0d want=%0d", wa.size() - b, PPF);
    end else begin
      for (int i = 0; i < PPF; i++) begin
        if (wa[b+i] !== 11'(i) || wd[b+i] !== (16'hFF00 | 16'(i))) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL frame2_words bad=%0d want=0", bad);
      end
    end
    checks++;
    if (fd_cnt - f !== 2 || display_buf !== 1'b0) begin
      failures++;
      $display("FAIL frame2_commit fd=%0d db=%b want 2/0",
               fd_cnt - f, display_buf);
    end
  endtask

  task automatic test_overflow();
    int b;
    int f;
    b = wa.size();
    f = fd_cnt;
    ss_low();
    for (int i = 0; i <= PPF; i++) send_bits(16'(i), 16);
    #80;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag got=%b want=1", overflow);
    end
    ss_high();
    checks++;
    if (wa.size() - b !== PPF) begin
      failures++;
      $display("FAIL ovf_count got=%0d want=%0d", wa.size() - b, PPF);
    end
    checks++;
    if (fd_cnt - f !== 1 || display_buf !== 1'b1 ||
        overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_commit fd=%0d db=%b ov=%b want 1/1/1",
               fd_cnt - f, display_buf, overflow);
    end
    ss_low();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b want=0", overflow);
    end
    ss_high();
  endtask

  task automatic test_back_to_back();
    logic [15:0] v[5];
    logic [10:0] a[5];
    int b;
    int f;
    int bad;
    v[0] = 16'h8001; v[1] = 16'h7FFE; v[2] = 16'h5A5A;
    v[3] = 16'hC3A5; v[4] = 16'h0F0F;
    a[0] = 11'h000;  a[1] = 11'h001;  a[2] = 11'h002;
    a[3] = 11'h000;  a[4] = 11'h001;
    b   = wa.size();
    f   = fd_cnt;
    dbl = 0;
    bad = 0;
    #($urandom_range(1, 9));
    spi_ss = 1'b0;
    #($urandom_range(60, 80));
    for (int i = 0; i < 3; i++) begin
      #($urandom_range(0, 9));
      send_bits(v[i], 16);
    end
    #40 spi_ss = 1'b1;
    #40 spi_ss = 1'b0;
    #($urandom_range(60, 80));
    for (int i = 3; i < 5; i++) begin
      #($urandom_range(0, 9));
      send_bits(v[i], 16);
    end
    ss_high();
    checks++;
    if (wa.size() - b !== 5) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=5", wa.size() - b);
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wd[b+i] !== v[i] || wa[b+i] !== a[i]) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL b2b_words bad=%0d want=0", bad);
      end
    end
    checks++;
    if (dbl !== 0 || fd_cnt !== f) begin
      failures++;
      $display("FAIL b2b_strobe dbl=%0d fd=%0d want 0/0",
               dbl, fd_cnt - f);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_pixel();
    test_partial_word();
    test_reset_mid_frame();
    test_full_frame();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
